rng_stream: RTL and testbench

Parametrised LFSR random-number source with a valid/ready output handshake, a runtime seed load, and optional lock-up protection. Each output word is built from OUT_W fresh LFSR shifts, so successive words never share bits. The block feeds game and test logic that draws random values on demand and replaces the fixed 8-bit free-running generator.

---
 rtl/rng_pkg.sv | 12 +
 rtl/rng_lfsr_core.sv | 55 +++++
 rtl/rng_stream.sv | 97 +++++++++
 tb/tb_rng_stream.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and default constants for the rng_stream LFSR random source.
package rng_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    VALID = 1'b1
  } rng_state_t;

  localparam logic [7:0] RNG_DEF_TAPS8 = 8'hB8;
  localparam logic [7:0] RNG_DEF_SEED8 = 8'hA9;

endpackage

// File: rtl/rng_lfsr_core.sv
// XNOR-feedback LFSR state register with step/load control.
// Optional macro RNG_LOCKUP_GUARD_EN replaces an all-ones seed with SEED and flags it.
module rng_lfsr_core #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0]  SEED  = 8'hA9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next,
  output logic             seed_err
);

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] load_val;

  // XNOR feedback: all-ones is the single lock-up state, all-zeros is legal.
  assign next  = {state_reg[WIDTH-2:0], ~^(state_reg & TAPS)};
  assign state = state_reg;

`ifdef RNG_LOCKUP_GUARD_EN
  logic lockup;
  logic seed_err_reg;

  assign lockup   = &seed_in;
  assign load_val = lockup ? SEED : seed_in;
  assign seed_err = seed_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_err_reg <= 1'b0;
    end else begin
      seed_err_reg <= load & lockup;
    end
  end
`else
  assign load_val = seed_in;
  assign seed_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SEED;
    end else if (load) begin
      state_reg <= load_val;
    end else if (step) begin
      state_reg <= next;
    end
  end

endmodule

// File: rtl/rng_stream.sv
// LFSR random-word source with valid/ready output; each word uses OUT_W fresh shifts.
// Lock-up seed protection is enabled by defining RNG_LOCKUP_GUARD_EN.
module rng_stream
  import rng_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = RNG_DEF_TAPS8,
  parameter logic [WIDTH-1:0] SEED  = RNG_DEF_SEED8,
  parameter int unsigned      OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_ld,
  input  logic [WIDTH-1:0] seed_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             seed_err
);

  localparam int unsigned     CW   = $clog2(OUT_W + 1);
  localparam logic [CW-1:0]   LAST = CW'(OUT_W - 1);

  rng_state_t       fsm_reg, fsm_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [OUT_W-1:0] data_reg, data_next;
  logic             step;
  logic [WIDTH-1:0] lfsr_state;
  logic [WIDTH-1:0] lfsr_next;

  rng_lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (step),
    .load     (seed_ld),
    .seed_in  (seed_in),
    .state    (lfsr_state),
    .next     (lfsr_next),
    .seed_err (seed_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg  <= FILL;
      cnt_reg  <= '0;
      data_reg <= '0;
    end else begin
      fsm_reg  <= fsm_next;
      cnt_reg  <= cnt_next;
      data_reg <= data_next;
    end
  end

  // A seed load overrides everything, including a simultaneous consume.
  always_comb begin
    fsm_next  = fsm_reg;
    cnt_next  = cnt_reg;
    data_next = data_reg;
    step      = 1'b0;
    if (seed_ld) begin
      fsm_next = FILL;
      cnt_next = '0;
    end else begin
      case (fsm_reg)
        FILL: begin
          if (en) begin
            step = 1'b1;
            if (cnt_reg == LAST) begin
              cnt_next  = '0;
              data_next = lfsr_next[OUT_W-1:0];
              fsm_next  = VALID;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
        end
        VALID: begin
          if (out_ready) fsm_next = FILL;
        end
        default: fsm_next = FILL;
      endcase
    end
  end

  assign out_valid = (fsm_reg == VALID);
  assign out_data  = data_reg;

  // Full LFSR state is observable only through out_data when OUT_W == WIDTH.
  logic unused_state;
  assign unused_state = ^lfsr_state;

endmodule

// File: tb/tb_rng_stream.sv
// Scoreboard bench for rng_stream at default parameters (8-bit LFSR, 8-bit words).
module tb_rng_stream;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       seed_ld;
  logic [7:0] seed_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       seed_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ms;
  int edges;
  int hits;
  logic [7:0] got_word;

  rng_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .seed_ld   (seed_ld),
    .seed_in   (seed_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .seed_err  (seed_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ~^(s & 8'hB8)};
  endfunction

  function automatic logic [7:0] word_from(input logic [7:0] s);
    logic [7:0] t;
    t = s;
    for (int k = 0; k < 8; k++) t = lfsr_step(t);
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until out_valid; optionally toggle en 1-0-1 per edge.
  task automatic wait_word(input string tag, input bit toggle, input int exp_edges);
    logic [7:0] exp_w;
    edges = 0;
    while (!out_valid && edges < 40) begin
      en = toggle ? ((edges % 2) == 0) : 1'b1;
      tick();
      edges++;
    end
    en = 1'b1;
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_latency"}, edges, exp_edges);
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    got_word = out_data;
    check({tag, "_data"}, out_data, exp_w);
    $display("word %s: data=%02h edges=%0d", tag, out_data, edges);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consume_clear", out_valid, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_data"}, out_data, 8'h00);
    check({tag, "_err"}, seed_err, 1'b0);
    #1;
    rst_n = 1'b1;
    ms = 8'hA9;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    seed_ld   = 1'b0;
    seed_in   = 8'h00;
    out_ready = 1'b0;
    ms        = 8'hA9;
    #12;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_err", seed_err, 1'b0);
    #1;
    rst_n = 1'b1;

    // First word from reset seed.
    exp_q.push_back(8'h29);
    ms = word_from(ms);
    wait_word("first", 1'b0, 8);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, 8'h29);
    end

    // 255 consumed words: model-checked, and 8'h29 recurs only at the end.
    hits = 0;
    for (int i = 0; i < 255; i++) begin
      consume();
      ms = word_from(ms);
      exp_q.push_back(ms);
      wait_word("seq", 1'b0, 8);
      if (got_word == 8'h29) hits++;
    end
    check("period_hits", hits, 1);
    check("period_last", got_word, 8'h29);

    // en toggling during fill.
    tick();
    async_reset("rst_valid_mid");
    exp_q.push_back(8'h29);
    ms = word_from(ms);
    wait_word("toggle", 1'b1, 15);

    // Seed load 4 shifts into a fill.
    consume();
    for (int i = 0; i < 4; i++) tick();
    seed_ld = 1'b1;
    seed_in = 8'h52;
    tick();
    seed_ld = 1'b0;
    check("seed_clear", out_valid, 1'b0);
    ms = word_from(8'h52);
    exp_q.push_back(ms);
    wait_word("seed52", 1'b0, 8);
    check("seed52_not29", (got_word != 8'h29), 1'b1);

    // Seed load coinciding with consume in VALID.
    seed_ld   = 1'b1;
    out_ready = 1'b1;
    seed_in   = 8'hA9;
    tick();
    seed_ld   = 1'b0;
    out_ready = 1'b0;
    check("seedcons_clear", out_valid, 1'b0);
    exp_q.push_back(8'h29);
    wait_word("seedcons", 1'b0, 8);

    // All-ones seed.
    seed_ld = 1'b1;
    seed_in = 8'hFF;
    tick();
    seed_ld = 1'b0;
`ifdef RNG_LOCKUP_GUARD_EN
    check("ff_err_pulse", seed_err, 1'b1);
    tick();
    check("ff_err_end", seed_err, 1'b0);
    exp_q.push_back(8'h29);
    wait_word("ff_guard", 1'b0, 7);
`else
    check("ff_err_pulse", seed_err, 1'b0);
    tick();
    check("ff_err_end", seed_err, 1'b0);
    exp_q.push_back(8'hFF);
    wait_word("ff_lock", 1'b0, 7);
    consume();
    exp_q.push_back(8'hFF);
    wait_word("ff_lock2", 1'b0, 8);
`endif

    // Reset mid-VALID, then mid-FILL.
    async_reset("rst_mid_valid");
    exp_q.push_back(8'h29);
    wait_word("after_rst_v", 1'b0, 8);
    consume();
    for (int i = 0; i < 3; i++) tick();
    async_reset("rst_mid_fill");
    exp_q.push_back(8'h29);
    wait_word("after_rst_f", 1'b0, 8);

    // out_ready while not valid has no effect on timing.
    consume();
    out_ready = 1'b1;
    exp_q.push_back(word_from(8'h29));
    wait_word("ready_idle", 1'b0, 8);
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
